dco_trk_word_gen: RTL

//  Tracking-bank word generator. Sits directly upstream of the 5x5 row/col tracking-bank coder.

---
 rtl/dco_pkg.sv | 15 +
 rtl/sd1_dither.sv | 32 +++
 rtl/dco_trk_word_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/dco_pkg.sv
// Shared definitions for the DCO tracking-bank path: coder range, centre word
// and the word generator's state encoding.
package dco_pkg;

    localparam int TRK_MAX    = 25;
    localparam int TRK_MID    = 12;
    localparam int TRK_WORD_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        TRACK
    } trk_state_t;

endpackage

// File: rtl/sd1_dither.sv
// First-order sigma-delta on the fractional tuning bits.
// carry is 1 on the cycles where the accumulator wraps.
module sd1_dither #(
    parameter int FRAC_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [FRAC_W-1:0] frac,
    output logic              carry
);

    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, frac};
    assign carry = sum[FRAC_W];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/dco_trk_word_gen.sv
// Tracking-bank word generator: settles at MID after enable, then tracks
// MID + otw with fractional dither and clipping to the coder range.
module dco_trk_word_gen
    import dco_pkg::*;
#(
    parameter int MAX        = TRK_MAX,
    parameter int MID        = TRK_MID,
    parameter int INT_W      = 6,
    parameter int FRAC_W     = 6,
    parameter int SETTLE_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    otw_valid,
    input  logic [INT_W+FRAC_W-1:0] otw,
    output logic [TRK_WORD_W-1:0]   word,
    output logic                    word_en,
    output logic                    sat_hi,
    output logic                    sat_lo,
    output logic                    busy
);

    localparam int RAW_W = INT_W + 2;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    trk_state_t              state;
    trk_state_t              state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [INT_W+FRAC_W-1:0] otw_q;
    logic [INT_W-1:0]        int_q;
    logic [FRAC_W-1:0]       frac_q;
    logic                    carry;
    logic                    upd;
    logic                    clip_hi;
    logic                    clip_lo;
    logic [RAW_W-1:0]        raw;

    assign int_q   = otw_q[INT_W+FRAC_W-1:FRAC_W];
    assign frac_q  = otw_q[FRAC_W-1:0];
    assign upd     = (state == TRACK) && en;
    assign word_en = (state == TRACK);
    assign busy    = (state == SETTLE);

    // Two's-complement sum; the MSB is the sign, so negative raw means clip low.
    assign raw     = {{(RAW_W-INT_W){int_q[INT_W-1]}}, int_q}
                   + RAW_W'(MID) + RAW_W'(carry);
    assign clip_lo = raw[RAW_W-1];
    assign clip_hi = !raw[RAW_W-1] && (raw > RAW_W'(MAX));

    sd1_dither #(
        .FRAC_W (FRAC_W)
    ) u_dither (
        .clk   (clk),
        .rst   (rst),
        .en    (upd),
        .clr   (!upd || clip_hi || clip_lo),
        .frac  (frac_q),
        .carry (carry)
    );

    // NOTE: every output of an always_comb gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (en) state_nxt = SETTLE;
            SETTLE:  if (!en) state_nxt = IDLE;
                     else if (cnt == CNT_W'(SETTLE_CYC - 1)) state_nxt = TRACK;
            TRACK:   if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Flags default low each cycle and are only raised by a TRACK update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word   <= TRK_WORD_W'(MID);
            sat_hi <= 1'b0;
            sat_lo <= 1'b0;
            cnt    <= '0;
            otw_q  <= '0;
        end else begin
            sat_hi <= 1'b0;
            sat_lo <= 1'b0;
            if (otw_valid) otw_q <= otw;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en) word <= TRK_WORD_W'(MID);
                end
                SETTLE: begin
                    cnt  <= cnt + CNT_W'(1);
                    word <= TRK_WORD_W'(MID);
                end
                TRACK: begin
                    if (en) begin
                        sat_hi <= clip_hi;
                        sat_lo <= clip_lo;
                        if (clip_hi)      word <= TRK_WORD_W'(MAX);
                        else if (clip_lo) word <= '0;
                        else              word <= raw[TRK_WORD_W-1:0];
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
